// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory stage behind the execute/memory pipeline latch. Non-memory results
// pass straight to the writeback registers. Loads and stores run over a
// req/ack data bus with byte-lane steering, and loads are sign/zero extended.
// While an access is outstanding the upstream latch is held through stall.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   aluIn, aluToRegIn, rdIn    ALU result/byte address, reg-write flag, dest reg
//   memSizeIn, memOpIn         access size (B/H/W) and kind (none/lds/st/ldu)
//   rs2ValIn                   store data
//   memReq/We/Addr/Be/Wdata    registered bus request, held until memAck
//   memRdata, memAck           read data, and its one-cycle completion pulse
//   stall                      combinational hold for the upstream latch
//   wbVal, wbRd, wbEn          registered writeback triple, wbEn single-cycle
//   misalign                   single-cycle fault pulse
//
// state | meaning
// IDLE  | accepting ops from the latch; ALU results are written back here
// REQ   | bus request outstanding, waiting for memAck
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluIn,
    input  logic        aluToRegIn,
    input  logic [1:0]  memSizeIn,
    input  logic [1:0]  memOpIn,
    input  logic [4:0]  rdIn,
    input  logic [31:0] rs2ValIn,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        stall,
    output logic [31:0] wbVal,
    output logic [4:0]  wbRd,
    output logic        wbEn,
    output logic        misalign
);

    typedef enum logic [0:0] {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic        memReq_q, memReq_d;
    logic        memWe_q, memWe_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [3:0]  memBe_q, memBe_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wbVal_q, wbVal_d;
    logic [4:0]  wbRd_q, wbRd_d;
    logic        wbEn_q, wbEn_d;
    logic        mis_q, mis_d;

    logic        access;
    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign access     = (memOpIn != 2'b00);
    assign misaligned = (memSizeIn == 2'b11) ||
                        (memSizeIn == 2'b01 && aluIn[0]) ||
                        (memSizeIn == 2'b10 && aluIn[1:0] != 2'b00);

    // Lane extraction works from the latched offset/size: the upstream
    // inputs are not trusted once the request is in flight.
    assign ld_byte = memRdata[{off_q, 3'b000} +: 8];
    assign ld_half = memRdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_val = memRdata;
        case (size_q)
            2'b00:   ld_val = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = memRdata;
        endcase
    end

    assign stall = ((state_q == IDLE) && access && !misaligned) ||
                   ((state_q == REQ) && !memAck);

    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memBe_d    = memBe_q;
        memWdata_d = memWdata_q;
        uns_d      = uns_q;
        size_d     = size_q;
        off_d      = off_q;
        rd_d       = rd_q;
        wbVal_d    = wbVal_q;
        wbRd_d     = wbRd_q;
        wbEn_d     = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!access) begin
                    wbVal_d = aluIn;
                    wbRd_d  = rdIn;
                    wbEn_d  = aluToRegIn && (rdIn != 5'd0);
                end else if (misaligned) begin
                    mis_d = 1'b1;
                end else begin
                    memReq_d  = 1'b1;
                    memWe_d   = (memOpIn == 2'b10);
                    memAddr_d = {aluIn[31:2], 2'b00};
                    uns_d     = (memOpIn == 2'b11);
                    size_d    = memSizeIn;
                    off_d     = aluIn[1:0];
                    rd_d      = rdIn;
                    case (memSizeIn)
                        2'b00: begin
                            memBe_d    = 4'b0001 << aluIn[1:0];
                            memWdata_d = {4{rs2ValIn[7:0]}};
                        end
                        2'b01: begin
                            memBe_d    = aluIn[1] ? 4'b1100 : 4'b0011;
                            memWdata_d = {2{rs2ValIn[15:0]}};
                        end
                        default: begin
                            memBe_d    = 4'b1111;
                            memWdata_d = rs2ValIn;
                        end
                    endcase
                    state_d = REQ;
                end
            end
            REQ: begin
                if (memAck) begin
                    memReq_d = 1'b0;
                    memWe_d  = 1'b0;
                    state_d  = IDLE;
                    if (!memWe_q) begin
                        wbVal_d = ld_val;
                        wbRd_d  = rd_q;
                        wbEn_d  = (rd_q != 5'd0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 32'd0;
            memBe_q    <= 4'd0;
            memWdata_q <= 32'd0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            rd_q       <= 5'd0;
            wbVal_q    <= 32'd0;
            wbRd_q     <= 5'd0;
            wbEn_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memBe_q    <= memBe_d;
            memWdata_q <= memWdata_d;
            uns_q      <= uns_d;
            size_q     <= size_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            wbVal_q    <= wbVal_d;
            wbRd_q     <= wbRd_d;
            wbEn_q     <= wbEn_d;
            mis_q      <= mis_d;
        end
    end

    assign memReq   = memReq_q;
    assign memWe    = memWe_q;
    assign memAddr  = memAddr_q;
    assign memBe    = memBe_q;
    assign memWdata = memWdata_q;
    assign wbVal    = wbVal_q;
    assign wbRd     = wbRd_q;
    assign wbEn     = wbEn_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vectors, expected writebacks and
// bus requests queued at issue time and checked by an independent monitor.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [31:0] aluIn;
    logic        aluToRegIn;
    logic [1:0]  memSizeIn;
    logic [1:0]  memOpIn;
    logic [4:0]  rdIn;
    logic [31:0] rs2ValIn;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;
    logic        stall;
    logic [31:0] wbVal;
    logic [4:0]  wbRd;
    logic        wbEn;
    logic        misalign;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .aluIn(aluIn), .aluToRegIn(aluToRegIn),
        .memSizeIn(memSizeIn), .memOpIn(memOpIn), .rdIn(rdIn), .rs2ValIn(rs2ValIn),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memBe(memBe),
        .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck), .stall(stall),
        .wbVal(wbVal), .wbRd(wbRd), .wbEn(wbEn), .misalign(misalign)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mis_seen = 0;
    logic req_prev = 1'b0;
    logic mis_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        aluIn = 32'd0; aluToRegIn = 1'b0; memSizeIn = 2'b00;
        memOpIn = 2'b00; rdIn = 5'd0; rs2ValIn = 32'd0;
    endtask

    // Monitor: compares on every DUT writeback strobe and every new request.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (wbEn) begin
                    if (wb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_unexpected: got rd=%0d val=0x%08h expected none", wbRd, wbVal);
                    end else begin
                        chk("wb_rd", {27'd0, wbRd}, {27'd0, wb_q[0].rd});
                        chk("wb_val", wbVal, wb_q[0].val);
                        void'(wb_q.pop_front());
                    end
                end
                if (memReq && !req_prev) begin
                    if (bus_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_unexpected: got addr=0x%08h expected none", memAddr);
                    end else begin
                        chk("bus_we", {31'd0, memWe}, {31'd0, bus_q[0].we});
                        chk("bus_addr", memAddr, bus_q[0].addr);
                        chk("bus_be", {28'd0, memBe}, {28'd0, bus_q[0].be});
                        if (bus_q[0].we) chk("bus_wdata", memWdata, bus_q[0].wdata);
                        void'(bus_q.pop_front());
                    end
                end
                if (misalign) begin
                    mis_seen++;
                    if (mis_prev) chk("misalign_pulse_width", 32'd2, 32'd1);
                end
            end
            req_prev = memReq;
            mis_prev = misalign;
        end
    end

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic en);
        memOpIn = 2'b00; aluIn = alu; rdIn = rd; aluToRegIn = en;
        if (en && rd != 5'd0) wb_q.push_back('{rd, alu});
        #2 chk("alu_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        idle();
        #2 chk("alu_wben", {31'd0, wbEn}, {31'd0, en && rd != 5'd0});
    endtask

    task automatic mem_op(input logic [1:0] op, input logic [1:0] size,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input int waits, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] wbv);
        int st;
        logic exp_en;
        st = 0;
        exp_en = (op != 2'b10) && (rd != 5'd0);
        memOpIn = op; memSizeIn = size; aluIn = alu; rdIn = rd;
        rs2ValIn = rs2; aluToRegIn = 1'b0;
        bus_q.push_back('{op == 2'b10, {alu[31:2], 2'b00}, be, wdata});
        if (exp_en) wb_q.push_back('{rd, wbv});
        #2 if (stall) st++;
        @(posedge clk); #1;
        // Upstream values change while the request is outstanding; the
        // access must use what was latched.
        aluIn = 32'hFFFF_FFFF; rdIn = 5'd31; rs2ValIn = 32'h1357_9BDF;
        memSizeIn = 2'b10; memOpIn = 2'b10;
        repeat (waits) begin
            #2 if (stall) st++;
            @(posedge clk); #1;
        end
        memAck = 1'b1; memRdata = rdata;
        #2 chk("stall_on_ack", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        memAck = 1'b0; memRdata = 32'hDEAD_0000;
        idle();
        chk("stall_cycles", st, waits + 1);
        #2 chk("wben_after_ack", {31'd0, wbEn}, {31'd0, exp_en});
        chk("req_dropped", {31'd0, memReq}, 32'd0);
    endtask

    task automatic mis_op(input logic [1:0] op, input logic [1:0] size, input logic [31:0] alu);
        memOpIn = op; memSizeIn = size; aluIn = alu; rdIn = 5'd3;
        #2 chk("mis_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        idle();
        #2 chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_no_req", {31'd0, memReq}, 32'd0);
        chk("mis_no_wb", {31'd0, wbEn}, 32'd0);
        @(posedge clk); #3;
        chk("mis_cleared", {31'd0, misalign}, 32'd0);
        chk("mis_still_no_req", {31'd0, memReq}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; memAck = 1'b0; memRdata = 32'd0;
        idle();
        #3;
        chk("rst_memReq", {31'd0, memReq}, 32'd0);
        chk("rst_memBe", {28'd0, memBe}, 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_wbVal", wbVal, 32'd0);
        chk("rst_wbEn", {31'd0, wbEn}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // Reset while a request is outstanding.
        memOpIn = 2'b01; memSizeIn = 2'b10; aluIn = 32'h0000_0400; rdIn = 5'd4;
        bus_q.push_back('{1'b0, 32'h0000_0400, 4'b1111, 32'd0});
        @(posedge clk); #1;
        chk("req_before_reset", {31'd0, memReq}, 32'd1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_memReq", {31'd0, memReq}, 32'd0);
        chk("abort_wbEn", {31'd0, wbEn}, 32'd0);
        chk("abort_memBe", {28'd0, memBe}, 32'd0);
        idle();
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_stall", {31'd0, stall}, 32'd0);
        chk("post_reset_req", {31'd0, memReq}, 32'd0);

        // Non-memory ops.
        alu_op(32'h1234_5678, 5'd5, 1'b1);
        alu_op(32'h1234_5678, 5'd0, 1'b1);
        alu_op(32'h0BAD_F00D, 5'd6, 1'b0);

        // memAck outside a request is ignored.
        memAck = 1'b1;
        @(posedge clk); #1;
        memAck = 1'b0;
        #2 chk("stray_ack_req", {31'd0, memReq}, 32'd0);
        chk("stray_ack_wb", {31'd0, wbEn}, 32'd0);

        // Loads and stores: op, size, addr, rs2, rdata, rd, waits, be, wdata, wb.
        mem_op(2'b01, 2'b00, 32'h0000_0103, 32'd0, 32'h80FF_0000, 5'd8, 3, 4'b1000, 32'd0, 32'hFFFF_FF80);
        mem_op(2'b11, 2'b00, 32'h0000_0103, 32'd0, 32'h80FF_0000, 5'd8, 3, 4'b1000, 32'd0, 32'h0000_0080);
        mem_op(2'b10, 2'b01, 32'h0000_0202, 32'hAAAA_BEEF, 32'd0, 5'd2, 1, 4'b1100, 32'hBEEF_BEEF, 32'd0);
        mem_op(2'b10, 2'b00, 32'h0000_0001, 32'h1234_565A, 32'd0, 5'd2, 0, 4'b0010, 32'h5A5A_5A5A, 32'd0);
        mem_op(2'b11, 2'b01, 32'h0000_0002, 32'd0, 32'h8001_1234, 5'd10, 2, 4'b1100, 32'd0, 32'h0000_8001);
        mem_op(2'b01, 2'b00, 32'h0000_0005, 32'd0, 32'h0000_7F00, 5'd0, 0, 4'b0010, 32'd0, 32'd0);
        mem_op(2'b01, 2'b10, 32'h0000_0300, 32'd0, 32'hDEAD_BEEF, 5'd7, 0, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        mem_op(2'b01, 2'b01, 32'h0000_0302, 32'd0, 32'h8001_1234, 5'd9, 0, 4'b1100, 32'd0, 32'hFFFF_8001);

        // Misaligned accesses.
        mis_op(2'b01, 2'b10, 32'h0000_0101);
        mis_op(2'b10, 2'b01, 32'h0000_0003);
        mis_op(2'b11, 2'b11, 32'h0000_0000);

        repeat (3) @(posedge clk);
        #3;
        chk("wb_queue_drained", wb_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        chk("misalign_count", mis_seen, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
